// File: rtl/inst_fetch_pkg.sv
// Shared CPU constants and the fetch-buffer entry layout.
package inst_fetch_pkg;
  localparam logic [5:0]  OP_J             = 6'b000010;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
  } fetch_entry_t;
endpackage

// File: rtl/inst_fetch_if.sv
// Fetch-unit bus: instruction memory port, redirect input and decode handshake.
interface inst_fetch_if;
  logic [31:0] addr;
  logic [31:0] inst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic [31:0] out_pc_plus4;

  modport master (
    output addr, out_valid, out_inst, out_pc, out_pc_plus4,
    input  inst, redirect, redirect_pc, out_ready
  );
  modport slave (
    input  addr, out_valid, out_inst, out_pc, out_pc_plus4,
    output inst, redirect, redirect_pc, out_ready
  );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Small FIFO of {inst, pc} entries; flush beats push/pop in the same edge.
module fetch_buffer
  import inst_fetch_pkg::*;
#(
  parameter int DEPTH = 2,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic          flush,
  input  fetch_entry_t  wdata,
  output fetch_entry_t  head,
  output logic [CW-1:0] count
);
  fetch_entry_t  mem [DEPTH];
  logic [AW-1:0] rptr, wptr;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else if (flush) begin
      rptr  <= '0;
      wptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + 1'b1;
      if (pop)  rptr <= rptr + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // Storage needs no reset: count gates visibility of every slot.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wptr] <= wdata;
  end

  assign head = mem[rptr];
endmodule

// File: rtl/inst_fetch.sv
// Fetch stage: PC register, jump predecode, and a 2-entry buffer toward decode.
module inst_fetch
  import inst_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter int          DEPTH    = 2,
  localparam int         CW       = $clog2(DEPTH + 1)
) (
  input  logic         clk,
  input  logic         rst,
  inst_fetch_if.master bus
);
  logic [31:0]   pc, pc4, pc_nxt;
  logic [CW-1:0] count;
  logic          valid, pop, push, full, is_j;
  fetch_entry_t  head, wdata;

  assign pc4   = pc + 32'd4;
  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid && bus.out_ready;
  // A pop frees the head slot at the same edge, so a full buffer can still accept.
  assign push  = !bus.redirect && (!full || pop);
  assign is_j  = (bus.inst[31:26] == OP_J);
  assign wdata = '{inst: bus.inst, pc: pc};

  always_comb begin
    pc_nxt = pc;
    if (bus.redirect)
      pc_nxt = bus.redirect_pc & ~32'h3;
    else if (push)
      pc_nxt = is_j ? {pc4[31:28], bus.inst[25:0], 2'b00} : pc4;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_nxt;
  end

  fetch_buffer #(.DEPTH(DEPTH)) u_buf (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (bus.redirect),
    .wdata (wdata),
    .head  (head),
    .count (count)
  );

  assign bus.addr         = pc;
  assign bus.out_valid    = valid;
  assign bus.out_inst     = head.inst;
  assign bus.out_pc       = head.pc;
  assign bus.out_pc_plus4 = head.pc + 32'd4;
endmodule

// File: doc/inst_fetch.md
INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h00000000, is the PC loaded on reset (word-aligned).
REQ-002 Parameter DEPTH, default 2, is the fetch-buffer entry count (fixed at 2; other values are unsupported).
REQ-003 Clk  input  1  is the single clock; all state updates occur on its rising edge.
REQ-004 Rst  input  1  is the asynchronous, active-high reset.
REQ-005 Addr  output  32  is the instruction address driven to the combinational instruction memory; it equals PC.
REQ-006 Inst  input  32  is the instruction word returned by memory for Addr in the same cycle.
REQ-007 Redirect  input  1  is a branch/jump redirect from a later stage (beq taken, etc.).
REQ-008 RedirectPC  input  32  is the target PC, valid while Redirect=1.
REQ-009 OutValid  output  1  means the buffer head holds a valid instruction.
REQ-010 OutReady  input  1  means decode accepts the head this cycle.
REQ-011 OutInst  output  32  is the head instruction.
REQ-012 OutPC  output  32  is the head instruction address.
REQ-013 OutPCPlus4  output  32  is OutPC+4, modulo 2^32.

Function
REQ-014 Addr SHALL equal the PC register combinationally; Inst SHALL be sampled in the same cycle (zero-latency memory).
REQ-015 Push: when Redirect=0 and the buffer has a free slot (count<2, or count=2 with a pop this cycle), {Inst, PC} SHALL be written to the tail and PC SHALL advance.
REQ-016 Next PC, in priority order: Redirect -> {RedirectPC[31:2],2'b00}; pushed Inst[31:26]=6'b000010 (j) -> {PC+4[31:28], Inst[25:0], 2'b00}; otherwise PC+4.
REQ-017 With no push and no Redirect, PC SHALL hold.
REQ-018 Pop: a handshake SHALL occur when OutValid=1 and OutReady=1, removing the head at the clock edge.
REQ-019 Redirect SHALL flush every buffer entry at the edge, including any entry not popped that cycle, and SHALL suppress the push in that cycle.
REQ-020 If Redirect and a handshake coincide, the handshake SHALL count as completed before the flush.
REQ-021 The first instruction at the redirect target SHALL appear on OutValid two edges after Redirect is sampled.
REQ-022 The buffer SHALL be FIFO-ordered: simultaneous push and pop when count=2 SHALL keep count=2; when count=1, push and pop together SHALL keep count=1.
REQ-023 OutInst, OutPC and OutPCPlus4 SHALL be driven from the head entry and held stable while OutValid=1 and OutReady=0.
REQ-024 PC+4 at 32'hFFFFFFFC SHALL wrap to 32'h00000000 without any flag.
REQ-025 In the steady state with OutReady held at 1 and no Redirect, the unit SHALL deliver one instruction per cycle.

Reset
REQ-026 Asserting Rst SHALL immediately set PC=RESET_PC, buffer count=0 and OutValid=0, regardless of Clk.
REQ-027 After Rst is released, the first edge SHALL push the instruction at RESET_PC, and OutValid SHALL be 1 from then on.
REQ-028 Rst asserted mid-stream SHALL discard all buffered entries; no partial handshake SHALL complete.

Structure
REQ-029 Opcode constants (OP_J=6'b000010) and RESET_PC_DEFAULT SHALL reside in the shared CPU package.
REQ-030 The buffer SHALL be a sub-module, fetch_buffer: 2-entry, 64-bit-wide FIFO with push, pop, flush, count, head and async Rst.
REQ-031 PC logic and jump predecode SHALL remain in inst_fetch.

Verification
REQ-032 Reset release, RESET_PC=0, OutReady=1: OutPC must be 0, 4, 8 on consecutive cycles, with OutInst matching memory words 0, 1, 2.
REQ-033 OutReady=0 for 5 cycles after reset: count must saturate at 2; Addr must hold 32'h8; OutPC must hold 0. Releasing OutReady must then yield 0, 4, 8 with no gaps.
REQ-034 j 15 at address 32'h4C: the next pushed PC must be 32'h3C, and the address 32'h50 must never be pushed.
REQ-035 Redirect=1, RedirectPC=32'h45, with a handshake in the same cycle: the buffer must flush, and the next OutPC must be 32'h44 after two edges.
REQ-036 Force PC to 32'hFFFFFFFC via redirect: the following OutPC must be 32'h0, and OutPCPlus4 must be 32'h0 while OutPC=32'hFFFFFFFC.
REQ-037 Assert Rst asynchronously between edges with count=2: OutValid must drop before the next edge, and Addr must equal RESET_PC.
